// File: rtl/music_pkg.sv
// Shared definitions for the music datapath: mixer state encoding,
// a constant clog2 and the signed sample range helpers.
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_EMIT    = 2'd3
  } mix_state_t;

  // Ceiling log2 for sizing counters and accumulators at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Largest value representable in a w-bit signed sample.
  function automatic longint sample_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit signed sample.
  function automatic longint sample_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Narrows a wide signed value to OUT_W bits.
// With VOICE_MIXER_SATURATE_EN defined the value is clamped to the signed
// OUT_W range and clip flags the clamp; otherwise the low bits are kept
// (two's-complement wrap) and clip is constant 0.
module mix_saturate
  import music_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val,
  output logic             clip
);

`ifdef VOICE_MIXER_SATURATE_EN
  localparam logic signed [IN_W-1:0] HI = IN_W'(sample_max(OUT_W));
  localparam logic signed [IN_W-1:0] LO = IN_W'(sample_min(OUT_W));

  logic signed [IN_W-1:0] in_s;
  assign in_s = in_val;

  // Clamp to the narrow range whenever the wide value does not fit.
  always_comb begin
    out_val = in_val[OUT_W-1:0];
    clip    = 1'b0;
    if (in_s > HI) begin
      out_val = HI[OUT_W-1:0];
      clip    = 1'b1;
    end else if (in_s < LO) begin
      out_val = LO[OUT_W-1:0];
      clip    = 1'b1;
    end
  end
`else
  // Upper bits are intentionally discarded by the wrap.
  logic unused_hi;
  assign unused_hi = ^in_val[IN_W-1:OUT_W];
  assign out_val   = in_val[OUT_W-1:0];
  assign clip      = 1'b0;
`endif

endmodule

// File: rtl/voice_mixer.sv
// N-voice mixer: captures each voice on its ready strobe, waits (with a
// timeout) for all active voices of the period, accumulates them one voice
// per cycle at full precision, shifts by GAIN_SHIFT and narrows via
// mix_saturate. Optional build macro: VOICE_MIXER_SATURATE_EN (saturate
// instead of wrap, drives clip).
//
// Handshake: voice_ready[i] is a one-cycle valid strobe with no back-pressure;
// the sample on voice_samples is taken in that cycle. mix_ready is a one-cycle
// valid strobe presented in the EMIT cycle together with the new mix_sample;
// the consumer cannot stall it.
//
// Timing: the last required voice_ready in cycle t is seen by COLLECT in t+1,
// ACCUM occupies t+2..t+1+N_VOICES, and EMIT (mix_ready high) is t+2+N_VOICES.
// state_dbg mirrors the FSM state for observation.
module voice_mixer
  import music_pkg::*;
#(
  parameter int N_VOICES   = 3,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_SHIFT = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         generate_next_sample,
  input  logic [N_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic [N_VOICES-1:0]          voice_ready,
  input  logic [N_VOICES-1:0]          voice_active,
  output logic [SAMPLE_W-1:0]          mix_sample,
  output logic                         mix_ready,
  output logic                         clip,
  output logic                         late,
  output logic                         overrun,
  output logic [1:0]                   state_dbg
);

  localparam int ACC_W  = SAMPLE_W + clog2(N_VOICES + 1);
  localparam int IDX_W  = clog2(N_VOICES + 1);
  localparam int TCNT_W = clog2(TIMEOUT + 1);

  mix_state_t state, state_next;

  logic [SAMPLE_W-1:0]      held [N_VOICES];
  logic [N_VOICES-1:0]      pending;
  logic [N_VOICES-1:0]      mask;
  logic [TCNT_W-1:0]        tcnt;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;

  logic [SAMPLE_W-1:0]      sel_sample;
  logic                     sel_en;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic [SAMPLE_W-1:0]      sat_out;
  logic                     sat_clip;

  logic start_period;
  logic all_in;
  logic timed_out;
  logic last_idx;

  assign start_period = (state == ST_IDLE) && generate_next_sample;
  assign all_in       = &(pending | ~mask);
  assign timed_out    = (tcnt == TCNT_W'(TIMEOUT - 1));
  assign last_idx     = (idx == IDX_W'(N_VOICES - 1));
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (generate_next_sample) state_next = ST_COLLECT;
      ST_COLLECT: if (all_in || timed_out) state_next = ST_ACCUM;
      ST_ACCUM:   if (last_idx) state_next = ST_EMIT;
      ST_EMIT:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Capture voices on their strobes; a strobe coinciding with the period-start
  // clear still leaves its pending bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < N_VOICES; i++) held[i] <= '0;
    end else begin
      pending <= (start_period ? '0 : pending) | voice_ready;
      for (int i = 0; i < N_VOICES; i++) begin
        if (voice_ready[i]) held[i] <= voice_samples[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Select the voice addressed by the accumulation index.
  always_comb begin
    sel_sample = '0;
    sel_en     = 1'b0;
    for (int i = 0; i < N_VOICES; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_sample = held[i];
        sel_en     = mask[i];
      end
    end
  end

  assign term      = sel_en ? {{(ACC_W-SAMPLE_W){sel_sample[SAMPLE_W-1]}}, sel_sample} : '0;
  assign acc_sum   = acc + term;
  assign acc_shift = acc_sum >>> GAIN_SHIFT;

  mix_saturate #(
    .IN_W  (ACC_W),
    .OUT_W (SAMPLE_W)
  ) u_sat (
    .in_val  (acc_shift),
    .out_val (sat_out),
    .clip    (sat_clip)
  );

  // Period bookkeeping, accumulation and registered output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask       <= '0;
      tcnt       <= '0;
      idx        <= '0;
      acc        <= '0;
      mix_sample <= '0;
      mix_ready  <= 1'b0;
      clip       <= 1'b0;
      late       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mix_ready <= 1'b0;
      clip      <= 1'b0;
      late      <= 1'b0;
      if (generate_next_sample && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (generate_next_sample) begin
            mask <= voice_active;
            tcnt <= '0;
          end
        end
        ST_COLLECT: begin
          if (all_in || timed_out) begin
            acc <= '0;
            idx <= '0;
            if (!all_in) late <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ST_ACCUM: begin
          acc <= acc_sum;
          idx <= idx + IDX_W'(1);
          if (last_idx) begin
            mix_sample <= sat_out;
            clip       <= sat_clip;
            mix_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: N=3, GAIN_SHIFT=0, TIMEOUT=8, plus a
// GAIN_SHIFT=2 instance fed the same inputs to cover the arithmetic shift.
module tb_voice_mixer;

  logic        clk;
  logic        reset;
  logic        generate_next_sample;
  logic [47:0] voice_samples;
  logic [2:0]  voice_ready;
  logic [2:0]  voice_active;

  logic [15:0] mix_sample;
  logic        mix_ready, clip, late, overrun;
  logic [1:0]  state_dbg;

  logic [15:0] g2_mix_sample;
  logic        g2_mix_ready, g2_clip, g2_late, g2_overrun;
  logic [1:0]  g2_state_dbg;

  int n_checks;
  int n_fail;

  voice_mixer #(.N_VOICES(3), .SAMPLE_W(16), .GAIN_SHIFT(0), .TIMEOUT(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .generate_next_sample (generate_next_sample),
    .voice_samples        (voice_samples),
    .voice_ready          (voice_ready),
    .voice_active         (voice_active),
    .mix_sample           (mix_sample),
    .mix_ready            (mix_ready),
    .clip                 (clip),
    .late                 (late),
    .overrun              (overrun),
    .state_dbg            (state_dbg)
  );

  voice_mixer #(.N_VOICES(3), .SAMPLE_W(16), .GAIN_SHIFT(2), .TIMEOUT(8)) dut_g2 (
    .clk                  (clk),
    .reset                (reset),
    .generate_next_sample (generate_next_sample),
    .voice_samples        (voice_samples),
    .voice_ready          (voice_ready),
    .voice_active         (voice_active),
    .mix_sample           (g2_mix_sample),
    .mix_ready            (g2_mix_ready),
    .clip                 (g2_clip),
    .late                 (g2_late),
    .overrun              (g2_overrun),
    .state_dbg            (g2_state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sample period: start in cycle 0, strobe rmask in cycle rdly
  // (-1 = never), and report the cycle of mix_ready relative to the start.
  task automatic do_period(input logic [2:0] act, input logic [47:0] smp,
                           input int rdly, input logic [2:0] rmask,
                           output int lat, output logic [15:0] res,
                           output logic res_clip, output logic saw_late,
                           output logic [15:0] g2_res, output logic g2_rdy);
    lat = -1; res = '0; res_clip = 1'b0; saw_late = 1'b0; g2_res = '0; g2_rdy = 1'b0;
    voice_active = act;
    voice_samples = smp;
    generate_next_sample = 1'b1;
    voice_ready = (rdly == 0) ? rmask : 3'b000;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      step();
      generate_next_sample = 1'b0;
      voice_ready = (rdly == n) ? rmask : 3'b000;
      if (late) saw_late = 1'b1;
      if (mix_ready) begin
        lat = n; res = mix_sample; res_clip = clip;
        g2_res = g2_mix_sample; g2_rdy = g2_mix_ready;
      end
    end
    voice_ready = 3'b000;
    step();
  endtask

  int          lat;
  logic [15:0] res, g2_res;
  logic        rclip, rlate, g2_rdy;
  int          cnt;
  logic [15:0] exp_pos, exp_neg;
  logic        exp_clip;

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    generate_next_sample = 1'b0;
    voice_samples = '0;
    voice_ready = '0;
    voice_active = '0;

`ifdef VOICE_MIXER_SATURATE_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000; exp_clip = 1'b1;
`else
    exp_pos = 16'h7FFD; exp_neg = 16'h8000; exp_clip = 1'b0;
`endif

    // Reset values.
    #1;
    check("rst_sample", mix_sample, 0);
    check("rst_ready", mix_ready, 0);
    check("rst_clip", clip, 0);
    check("rst_late", late, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state_dbg, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Basic mix 1000 + 2000 - 500, ready two cycles after the start.
    do_period(3'b111, {16'hFE0C, 16'h07D0, 16'h03E8}, 2, 3'b111, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("basic_lat", lat, 7);
    check("basic_sample", res, 16'h09C4);
    check("basic_clip", rclip, 0);
    check("basic_late", rlate, 0);
    check("basic_g2_rdy", g2_rdy, 1);
    check("basic_g2_sample", g2_res, 16'h0271);
    check("hold_sample", mix_sample, 16'h09C4);
    check("hold_ready", mix_ready, 0);

    // Masked voice1 never ready; strobes coincide with the period start.
    do_period(3'b101, {16'hFED4, 16'h3039, 16'h0064}, 0, 3'b101, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("mask_lat", lat, 5);
    check("mask_sample", res, 16'hFF38);
    check("mask_g2_sample", g2_res, 16'hFFCE);

    // Empty mask completes at once with a zero result.
    do_period(3'b000, {16'h1111, 16'h2222, 16'h3333}, -1, 3'b000, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("zero_lat", lat, 5);
    check("zero_sample", res, 0);
    check("zero_late", rlate, 0);

    // Positive overflow: 3 x 0x7FFF.
    do_period(3'b111, {16'h7FFF, 16'h7FFF, 16'h7FFF}, 0, 3'b111, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("satp_lat", lat, 5);
    check("satp_sample", res, exp_pos);
    check("satp_clip", rclip, exp_clip);
    check("satp_g2_sample", g2_res, 16'h5FFF);

    // Negative overflow: 3 x 0x8000.
    do_period(3'b111, {16'h8000, 16'h8000, 16'h8000}, 1, 3'b111, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("satn_lat", lat, 6);
    check("satn_sample", res, exp_neg);
    check("satn_clip", rclip, exp_clip);
    check("satn_g2_sample", g2_res, 16'hA000);

    // Prime held[2] = 50 with a full period 10 + 20 + 50.
    do_period(3'b111, {16'h0032, 16'h0014, 16'h000A}, 1, 3'b111, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("prime_sample", res, 16'h0050);
    check("prime_g2_sample", g2_res, 16'h0014);

    // Timeout: voice2 never ready, stale held[2] = 50 is used.
    do_period(3'b111, {16'h1E61, 16'h0014, 16'h000A}, 1, 3'b011, lat, res, rclip, rlate, g2_res, g2_rdy);
    check("tmo_late", rlate, 1);
    check("tmo_lat", lat, 12);
    check("tmo_sample", res, 16'h0050);

    // Overrun: period start pulsed again during ACCUM.
    check("ovr_pre", overrun, 0);
    voice_active = 3'b111;
    voice_samples = {16'h0003, 16'h0002, 16'h0001};
    voice_ready = 3'b111;
    generate_next_sample = 1'b1;
    cnt = 0;
    res = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      voice_ready = 3'b000;
      generate_next_sample = (n == 3);
      if (mix_ready) begin
        cnt++;
        res = mix_sample;
      end
    end
    check("ovr_ready_count", cnt, 1);
    check("ovr_sample", res, 16'h0006);
    check("ovr_sticky", overrun, 1);

    // Reset asserted asynchronously in the middle of ACCUM.
    voice_ready = 3'b111;
    generate_next_sample = 1'b1;
    step();
    voice_ready = 3'b000;
    generate_next_sample = 1'b0;
    step();
    step();
    check("mid_state_accum", state_dbg, 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_sample", mix_sample, 0);
    check("mid_rst_ready", mix_ready, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_state", state_dbg, 0);
    step();
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (mix_ready) cnt++;
    end
    check("mid_rst_no_ready", cnt, 0);
    check("mid_rst_overrun_after", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
